// File: rtl/tinytpu_pkg.sv
// tinytpu_pkg: shared link state encoding, default widths and counter sizing
package tinytpu_pkg;
  localparam int D_W_DEF  = 8;
  localparam int WORD_DEF = 4;
  localparam int R_W_DEF  = 2 * D_W_DEF;
  typedef enum logic [2:0] {IDLE, SHIFT, INIT, WAIT, RECV, DONE} link_state_t;
  function automatic int cnt_w(input int word, input int r_w);
    return $clog2(word * r_w + 1);
  endfunction
endpackage

// File: rtl/tinytpu_sipo.sv
// tinytpu_sipo: serial-in/parallel-out register, new bits enter at the MSB
module tinytpu_sipo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  // clear wins over shift so a new transfer never sees stale bits
  always_ff @(posedge clk) r_q <= i_clr ? '0 : i_en ? {i_d, r_q[W-1:1]} : r_q;
  assign o_q = r_q;
endmodule

// File: rtl/tinytpu_host_link.sv
// tinytpu_host_link: parallel host <-> tinytpu serial link; TINYTPU_LINK_TIMEOUT_EN adds a tx_ready watchdog
module tinytpu_host_link
  import tinytpu_pkg::*;
#(
  parameter int D_W  = D_W_DEF,
  parameter int WORD = WORD_DEF,
  parameter int R_W  = 2 * D_W
`ifdef TINYTPU_LINK_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD*D_W-1:0] x_vec,
  input  logic [WORD*D_W-1:0] y_vec,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WORD*R_W-1:0] res_data,
  output logic                err,
  output logic                data_in_x,
  output logic                data_in_y,
  output logic                load_en,
  output logic                init,
  input  logic                data_out_z,
  input  logic                tx_ready
);
  localparam int XW = WORD * D_W;
  localparam int RW = WORD * R_W;
  localparam int CW = cnt_w(WORD, R_W);
  localparam logic [CW-1:0] SH_LAST = CW'(XW - 1);
  localparam logic [CW-1:0] RX_LAST = CW'(RW - 1);
  link_state_t   r_state, w_next;
  logic [XW-1:0] r_x, r_y;
  logic [CW-1:0] r_cnt;
  logic          w_accept, w_busy, w_cap, w_timeout;
  assign w_accept = (r_state == IDLE) & in_valid;
  assign w_busy   = (r_state == WAIT) | (r_state == RECV);
  assign w_cap    = w_busy & tx_ready;
`ifdef TINYTPU_LINK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wd;
  logic            r_err;
  assign w_timeout = w_busy & ~tx_ready & (r_wd == WD_W'(TIMEOUT - 1));
  // count consecutive idle receive cycles; any captured bit restarts the count
  always_ff @(posedge clk) begin
    r_wd  <= (rst | ~w_busy | tx_ready) ? '0 : r_wd + WD_W'(1);
    r_err <= ~rst & w_timeout;
  end
  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = in_valid ? SHIFT : IDLE;
      SHIFT:      w_next = (r_cnt == SH_LAST) ? INIT : SHIFT;
      INIT:       w_next = WAIT;
      WAIT, RECV: w_next = w_cap ? ((r_cnt == RX_LAST) ? DONE : RECV) : w_timeout ? IDLE : r_state;
      DONE:       w_next = res_ready ? IDLE : DONE;
      default:    w_next = IDLE;
    endcase
  end
  // operand shift registers and the shared bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_x   <= x_vec;
      r_y   <= y_vec;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_x   <= r_x >> 1;
      r_y   <= r_y >> 1;
      r_cnt <= (r_cnt == SH_LAST) ? '0 : r_cnt + CW'(1);
    end else if (w_cap) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
  tinytpu_sipo #(.W(RW)) u_sipo (
    .clk  (clk),
    .i_clr(rst | w_accept),
    .i_en (w_cap),
    .i_d  (data_out_z),
    .o_q  (res_data)
  );
  assign in_ready  = r_state == IDLE;
  assign load_en   = r_state == SHIFT;
  assign init      = r_state == INIT;
  assign res_valid = r_state == DONE;
  assign data_in_x = r_x[0];
  assign data_in_y = r_y[0];
endmodule

// File: doc/tinytpu_host_link.md
# tinytpu_host_link

Host-side end of the tinytpu serial link. Accepts one pair of parallel operand vectors, serializes them bit-wise onto the tinytpu `data_in_x`/`data_in_y` lines under `load_en`, and pulses `init`. It then deserializes the result stream qualified by `tx_ready` on `data_out_z` and presents the result vector with a valid/ready handshake. It sits between a parallel host (test harness, bus bridge) and `tinytpu_top`.

## Interface
- `D_W`, 8, operand element width in bits
- `WORD`, 4, elements per operand and result vector
- `R_W`, 2*D_W, result element width in bits
- `TIMEOUT`, 1024, max consecutive idle cycles waiting for `tx_ready` (only with macro)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  operand pair offered
- `in_ready`  out  1  block idle, will accept
- `x_vec`  in  WORD*D_W  X operands, element 0 in LSBs
- `y_vec`  in  WORD*D_W  Y operands, element 0 in LSBs
- `res_valid`  out  1  `res_data` holds a complete result
- `res_ready`  in  1  host consumes result
- `res_data`  out  WORD*R_W  result, element 0 in LSBs
- `err`  out  1  one-cycle timeout pulse (0 without macro)
- `data_in_x`, `data_in_y`  out  1  serial operand bits to tinytpu
- `load_en`  out  1  operand bits valid
- `init`  out  1  one-cycle compute start
- `data_out_z`  in  1  serial result bit from tinytpu
- `tx_ready`  in  1  `data_out_z` valid this cycle

## Operation
- States: IDLE, SHIFT, INIT, WAIT, RECV, DONE. All link outputs driven from registers; no combinational input-to-output path.
- IDLE: `in_ready`=1. On `in_valid`: latch `x_vec`/`y_vec` into shift registers, clear bit counter, go SHIFT.
- SHIFT: `load_en`=1, `data_in_x`/`data_in_y` = bit 0 of shift registers, shift right each cycle. LSB-first, element 0 first. After WORD*D_W cycles go INIT.
- INIT: `init`=1 for exactly one cycle, `load_en`=0; go WAIT.
- WAIT/RECV: every cycle with `tx_ready`=1 shifts `data_out_z` into the MSB of the receive register and increments the count. WAIT moves to RECV on the first captured bit. Gaps (`tx_ready`=0) stall without losing bits. At WORD*R_W bits go DONE.
- DONE: `res_valid`=1, `res_data` stable until `res_valid & res_ready`, then IDLE.
- Ignored inputs: `tx_ready` in IDLE/SHIFT/INIT/DONE; `in_valid` outside IDLE.
- Reset values: all outputs 0, except `in_ready`=1. Receive register and state cleared (IDLE). Reset at any point aborts the transfer without emitting `res_valid` or `err`.

## Timing
- Acceptance edge at cycle T: `load_en` high cycles T+1..T+WORD*D_W (32 by default). `init` high at T+WORD*D_W+1.
- The first `tx_ready` bit is accepted the cycle after `init` at the earliest.
- `res_valid` rises the cycle after the last captured bit.
- If `res_ready` is already high, DONE lasts one cycle. `in_ready` rises the following cycle.
- Minimum transaction: WORD*D_W + WORD*R_W + 3 cycles.

## Configuration
- `TINYTPU_LINK_TIMEOUT_EN` defined: a watchdog counts consecutive `tx_ready`=0 cycles in WAIT/RECV and clears on any `tx_ready`=1. When it reaches TIMEOUT: `err`=1 for one cycle, partial result discarded, return to IDLE, no `res_valid`.
- Undefined: no counter, `err` tied 0, and the block waits indefinitely.

## Structure
- Package `tinytpu_pkg`: state enum `link_state_t`, default `D_W`/`WORD`/`R_W` constants, and the counter width function (clog2 of WORD*R_W+1).
- One sub-module: `tinytpu_sipo`, a parametric serial-in/parallel-out register with shift enable and clear, used for result capture.

## Test plan
- x_vec=32'h04030201, y_vec=32'h08070605 -> `data_in_x` is 1,0,0,0,0,0,0,0,0,1,… and `load_en` is high exactly 32 cycles. `init` is a single pulse on the next cycle.
- After `init`, drive 64 contiguous `tx_ready` bits of 64'h0040_0030_0020_000A, LSB first -> `res_valid` the next cycle with `res_data`=64'h0040_0030_0020_000A.
- Same frame with `tx_ready` dropped for 5 cycles after bit 20 -> identical `res_data`, `res_valid` 5 cycles later.
- Hold `res_ready`=0 for 10 cycles -> `res_data` stable, `in_ready`=0, and `in_valid` is ignored until the handshake.
- Assert `rst` during SHIFT bit 12 -> next cycle: `load_en`=0, `in_ready`=1. A fresh transaction then completes correctly.
- With `TINYTPU_LINK_TIMEOUT_EN`, TIMEOUT=16, and no `tx_ready` after `init` -> `err` pulses exactly once 16 cycles into WAIT, then IDLE, with no `res_valid`.
